pipe_idexe_reg: RTL and testbench

//  ID->EXE pipeline register feeding the execute stage. Latches decoded operands
//  and control, and registers the ALU A/B source selects (adepend/bdepend) from

---
 rtl/pipe_idexe_reg.sv | 203 ++++++++++++++++++++
 tb/tb_pipe_idexe_reg.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_idexe_reg.sv
// ID->EXE pipeline register.
// Latches decoded operands/control and precomputes the ALU A/B source selects
// (00 reg, 01 sa/imm, 10 forward from EXE result, 11 forward from MEM result).
// Detects a load-use hazard against the instruction in EXE, raises stall and
// inserts a bubble. A flush kills the decode-slot instruction and wins over stall.
// Optional build macro PIPE_IDEXE_PERF_EN adds stall/bubble event counters.
module pipe_idexe_reg #(
   parameter int DW  = 32,
   parameter int RW  = 5,
   parameter int ACW = 5
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           d_valid,
   input  logic [RW-1:0]  d_rs,
   input  logic [RW-1:0]  d_rt,
   input  logic [RW-1:0]  d_rn,
   input  logic           d_wreg,
   input  logic           d_m2reg,
   input  logic           d_wmem,
   input  logic           d_shift,
   input  logic           d_aluimm,
   input  logic           d_jal,
   input  logic [ACW-1:0] d_aluc,
   input  logic [DW-1:0]  d_ra,
   input  logic [DW-1:0]  d_rb,
   input  logic [DW-1:0]  d_imm,
   input  logic [DW-1:0]  d_pc4,
   input  logic           flush,
   input  logic [RW-1:0]  m_rn,
   input  logic           m_wreg,
   output logic           stall,
   output logic           e_valid,
   output logic [DW-1:0]  ea,
   output logic [DW-1:0]  eb,
   output logic [DW-1:0]  eimm,
   output logic [DW-1:0]  epc4,
   output logic [RW-1:0]  ern0,
   output logic [ACW-1:0] ealuc,
   output logic           ejal,
   output logic           ewreg,
   output logic           em2reg,
   output logic           ewmem,
   output logic [1:0]     adepend,
   output logic [1:0]     bdepend
`ifdef PIPE_IDEXE_PERF_EN
   ,
   output logic [31:0]    stall_cnt,
   output logic [31:0]    bubble_cnt
`endif
);

   // Source-select encodings
   localparam logic [1:0] SEL_REG  = 2'b00;
   localparam logic [1:0] SEL_IMM  = 2'b01;
   localparam logic [1:0] SEL_EALU = 2'b10;
   localparam logic [1:0] SEL_MALU = 2'b11;

   // EXE-stage state
   logic           e_valid_q, e_valid_d;
   logic [DW-1:0]  ea_q, ea_d;
   logic [DW-1:0]  eb_q, eb_d;
   logic [DW-1:0]  eimm_q, eimm_d;
   logic [DW-1:0]  epc4_q, epc4_d;
   logic [RW-1:0]  ern0_q, ern0_d;
   logic [ACW-1:0] ealuc_q, ealuc_d;
   logic           ejal_q, ejal_d;
   logic           ewreg_q, ewreg_d;
   logic           em2reg_q, em2reg_d;
   logic           ewmem_q, ewmem_d;
   logic [1:0]     adepend_q, adepend_d;
   logic [1:0]     bdepend_q, bdepend_d;

   // Hazard / forwarding terms
   logic [RW-1:0]  e_rn;
   logic           use_a, use_b;
   logic           hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
   logic           stall_c;
   logic           bubble;

   // Compare decode sources against the EXE (jal-adjusted) and MEM destinations
   always_comb begin
      e_rn     = ern0_q | {RW{ejal_q}};
      use_a    = ~d_shift;
      use_b    = ~d_aluimm | d_wmem;
      hit_e_rs = e_valid_q & ewreg_q & (e_rn != '0) & (e_rn == d_rs);
      hit_e_rt = e_valid_q & ewreg_q & (e_rn != '0) & (e_rn == d_rt);
      hit_m_rs = m_wreg & (m_rn != '0) & (m_rn == d_rs);
      hit_m_rt = m_wreg & (m_rn != '0) & (m_rn == d_rt);
   end

   // Load-use stall (suppressed by flush) and bubble insertion decision
   always_comb begin
      stall_c = resetn & d_valid & ~flush & e_valid_q & em2reg_q &
                ((use_a & hit_e_rs) | (use_b & hit_e_rt));
      bubble  = flush | stall_c | ~d_valid;
   end

   // Next EXE contents: datapath always follows decode, control is killed on a bubble
   always_comb begin
      ea_d      = d_ra;
      eb_d      = d_rb;
      eimm_d    = d_imm;
      epc4_d    = d_pc4;
      ern0_d    = d_rn;
      ealuc_d   = d_aluc;
      e_valid_d = 1'b0;
      ejal_d    = 1'b0;
      ewreg_d   = 1'b0;
      em2reg_d  = 1'b0;
      ewmem_d   = 1'b0;
      adepend_d = SEL_REG;
      bdepend_d = SEL_REG;
      if (!bubble) begin
         e_valid_d = 1'b1;
         ejal_d    = d_jal;
         ewreg_d   = d_wreg;
         em2reg_d  = d_m2reg;
         ewmem_d   = d_wmem;
         // EXE match beats MEM match: it carries the newest value
         if (d_shift)       adepend_d = SEL_IMM;
         else if (hit_e_rs) adepend_d = SEL_EALU;
         else if (hit_m_rs) adepend_d = SEL_MALU;
         if (d_aluimm)      bdepend_d = SEL_IMM;
         else if (hit_e_rt) bdepend_d = SEL_EALU;
         else if (hit_m_rt) bdepend_d = SEL_MALU;
      end
   end

   // EXE-stage register bank with asynchronous clear
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         e_valid_q <= 1'b0;
         ea_q      <= '0;
         eb_q      <= '0;
         eimm_q    <= '0;
         epc4_q    <= '0;
         ern0_q    <= '0;
         ealuc_q   <= '0;
         ejal_q    <= 1'b0;
         ewreg_q   <= 1'b0;
         em2reg_q  <= 1'b0;
         ewmem_q   <= 1'b0;
         adepend_q <= SEL_REG;
         bdepend_q <= SEL_REG;
      end else begin
         e_valid_q <= e_valid_d;
         ea_q      <= ea_d;
         eb_q      <= eb_d;
         eimm_q    <= eimm_d;
         epc4_q    <= epc4_d;
         ern0_q    <= ern0_d;
         ealuc_q   <= ealuc_d;
         ejal_q    <= ejal_d;
         ewreg_q   <= ewreg_d;
         em2reg_q  <= em2reg_d;
         ewmem_q   <= ewmem_d;
         adepend_q <= adepend_d;
         bdepend_q <= bdepend_d;
      end
   end

   assign stall   = stall_c;
   assign e_valid = e_valid_q;
   assign ea      = ea_q;
   assign eb      = eb_q;
   assign eimm    = eimm_q;
   assign epc4    = epc4_q;
   assign ern0    = ern0_q;
   assign ealuc   = ealuc_q;
   assign ejal    = ejal_q;
   assign ewreg   = ewreg_q;
   assign em2reg  = em2reg_q;
   assign ewmem   = ewmem_q;
   assign adepend = adepend_q;
   assign bdepend = bdepend_q;

`ifdef PIPE_IDEXE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Event counters, free-running with natural 32-bit wrap
   always_comb begin
      stall_cnt_d  = stall_cnt_q + {31'd0, stall_c};
      bubble_cnt_d = bubble_cnt_q + {31'd0, bubble};
   end

   // Counter registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_idexe_reg.sv
// Testbench for pipe_idexe_reg: directed forwarding/hazard scenarios with literal
// expectations, then randomized decode traffic checked every cycle against a
// transaction-level model of the instruction sitting in EXE.
module tb_pipe_idexe_reg;

   logic        clock = 1'b0;
   logic        resetn;
   logic        d_valid;
   logic [4:0]  d_rs, d_rt, d_rn;
   logic        d_wreg, d_m2reg, d_wmem, d_shift, d_aluimm, d_jal;
   logic [4:0]  d_aluc;
   logic [31:0] d_ra, d_rb, d_imm, d_pc4;
   logic        flush;
   logic [4:0]  m_rn;
   logic        m_wreg;
   logic        stall, e_valid;
   logic [31:0] ea, eb, eimm, epc4;
   logic [4:0]  ern0, ealuc;
   logic        ejal, ewreg, em2reg, ewmem;
   logic [1:0]  adepend, bdepend;
`ifdef PIPE_IDEXE_PERF_EN
   logic [31:0] stall_cnt, bubble_cnt;
   logic [31:0] mdl_stall_cnt, mdl_bubble_cnt;
   logic [31:0] snap_sc, snap_bc;
`endif

   int chk_cnt = 0;
   int err_cnt = 0;
   bit started = 0;

   always #5 clock = ~clock;

   pipe_idexe_reg dut (
      .clock(clock), .resetn(resetn), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
      .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
      .d_shift(d_shift), .d_aluimm(d_aluimm), .d_jal(d_jal),
      .d_aluc(d_aluc), .d_ra(d_ra), .d_rb(d_rb), .d_imm(d_imm), .d_pc4(d_pc4),
      .flush(flush), .m_rn(m_rn), .m_wreg(m_wreg),
      .stall(stall), .e_valid(e_valid), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4),
      .ern0(ern0), .ealuc(ealuc), .ejal(ejal), .ewreg(ewreg), .em2reg(em2reg),
      .ewmem(ewmem), .adepend(adepend), .bdepend(bdepend)
`ifdef PIPE_IDEXE_PERF_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   // ---------------- behavioural model: the instruction held in EXE -------------
   typedef struct packed {
      logic        valid;
      logic [31:0] a, b, imm, pc4;
      logic [4:0]  rn, aluc;
      logic        jal, wreg, m2reg, wmem;
      logic [1:0]  ad, bd;
   } exe_t;

   exe_t mdl;

   // Does instruction x produce register r (r0 is never a real producer)?
   function automatic logic exe_writes(input exe_t x, input logic [4:0] r);
      logic [4:0] dest;
      dest = x.jal ? 5'd31 : x.rn;
      return x.valid && x.wreg && (r != 5'd0) && (dest == r);
   endfunction

   function automatic logic mem_writes(input logic [4:0] r);
      return m_wreg && (r != 5'd0) && (m_rn == r);
   endfunction

   // Where an ALU operand must come from
   function automatic logic [1:0] source_of(input logic override, input logic [4:0] r);
      if (override)           return 2'd1;
      if (exe_writes(mdl, r)) return 2'd2;
      if (mem_writes(r))      return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic model_stall();
      logic needs_a, needs_b;
      needs_a = !d_shift && exe_writes(mdl, d_rs);
      needs_b = (!d_aluimm || d_wmem) && exe_writes(mdl, d_rt);
      return (resetn === 1'b1) && d_valid && !flush && mdl.valid && mdl.m2reg && (needs_a || needs_b);
   endfunction

   function automatic exe_t model_next();
      exe_t n;
      n = '0;
      if (d_valid && !flush && !model_stall()) begin
         n.valid = 1'b1;
         n.a = d_ra;  n.b = d_rb;  n.imm = d_imm;  n.pc4 = d_pc4;
         n.rn = d_rn; n.aluc = d_aluc;
         n.jal = d_jal; n.wreg = d_wreg; n.m2reg = d_m2reg; n.wmem = d_wmem;
         n.ad = source_of(d_shift, d_rs);
         n.bd = source_of(d_aluimm, d_rt);
      end
      return n;
   endfunction

   // Model advances on each edge, cleared asynchronously like the pipeline
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mdl <= '0;
`ifdef PIPE_IDEXE_PERF_EN
         mdl_stall_cnt  <= 32'd0;
         mdl_bubble_cnt <= 32'd0;
`endif
      end else begin
         mdl <= model_next();
`ifdef PIPE_IDEXE_PERF_EN
         mdl_stall_cnt  <= mdl_stall_cnt + (model_stall() ? 32'd1 : 32'd0);
         mdl_bubble_cnt <= mdl_bubble_cnt + ((d_valid && !flush && !model_stall()) ? 32'd0 : 32'd1);
`endif
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: registered outputs and combinational stall on every falling edge
   always @(negedge clock) begin
      if (started) begin
         check("stall", stall, model_stall());
         check("e_valid", e_valid, mdl.valid);
         check("ctrl", {ejal, ewreg, em2reg, ewmem}, {mdl.jal, mdl.wreg, mdl.m2reg, mdl.wmem});
         check("adepend", adepend, mdl.ad);
         check("bdepend", bdepend, mdl.bd);
         if (mdl.valid) begin
            check("ea_eb", {ea, eb}, {mdl.a, mdl.b});
            check("eimm_epc4", {eimm, epc4}, {mdl.imm, mdl.pc4});
            check("ern0_ealuc", {ern0, ealuc}, {mdl.rn, mdl.aluc});
         end
`ifdef PIPE_IDEXE_PERF_EN
         check("stall_cnt", stall_cnt, mdl_stall_cnt);
         check("bubble_cnt", bubble_cnt, mdl_bubble_cnt);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rn, input logic wreg, input logic m2reg,
                          input logic shift, input logic aluimm, input logic jal,
                          input logic fl);
      d_valid = v; d_rs = rs; d_rt = rt; d_rn = rn;
      d_wreg = wreg; d_m2reg = m2reg; d_wmem = 1'b0;
      d_shift = shift; d_aluimm = aluimm; d_jal = jal; flush = fl;
      d_aluc = 5'($urandom); d_ra = $urandom; d_rb = $urandom;
      d_imm = $urandom; d_pc4 = $urandom;
   endtask

   function automatic logic [4:0] pick_reg();
      int r;
      r = $urandom_range(0, 5);
      return (r == 5) ? 5'd31 : 5'(r);
   endfunction

   task automatic randomize_inputs();
      d_valid  = ($urandom_range(0, 99) < 85);
      flush    = ($urandom_range(0, 99) < 10);
      d_rs     = pick_reg();
      d_rt     = pick_reg();
      d_rn     = pick_reg();
      d_wreg   = ($urandom_range(0, 99) < 70);
      d_m2reg  = ($urandom_range(0, 99) < 35);
      d_wmem   = ($urandom_range(0, 99) < 15);
      d_shift  = ($urandom_range(0, 99) < 20);
      d_aluimm = ($urandom_range(0, 99) < 30);
      d_jal    = ($urandom_range(0, 99) < 10);
      d_aluc   = 5'($urandom);
      d_ra = $urandom; d_rb = $urandom; d_imm = $urandom; d_pc4 = $urandom;
      m_rn     = pick_reg();
      m_wreg   = ($urandom_range(0, 99) < 60);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      resetn = 1'b0;
      set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_rn = 5'd0; m_wreg = 1'b0;
      @(posedge clock);
      #1 started = 1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_e_valid", e_valid, 1'b0);
      check("reset_sel", {adepend, bdepend}, 4'b0000);
      check("reset_stall", stall, 1'b0);
      #1 resetn = 1'b1;

      // T2: EXE forward
      set_dec(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("t2_stall", stall, 1'b0);
      tick();
      check("t2_adepend", adepend, 2'b10);
      check("t2_bdepend", bdepend, 2'b00);
      $display("T2 exe-fwd    : adepend=%b bdepend=%b", adepend, bdepend);

      // T3: EXE beats MEM, then MEM alone
      m_rn = 5'd5; m_wreg = 1'b1;
      set_dec(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd5, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("t3_exe_prio", adepend, 2'b10);
      $display("T3 exe-prio   : adepend=%b", adepend);
      set_dec(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd5, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("t3_mem_fwd", adepend, 2'b11);
      $display("T3 mem-fwd    : adepend=%b", adepend);
      m_wreg = 1'b0;

      // T4: load-use stall, bubble, then MEM forward
      set_dec(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd7, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("t4_stall", stall, 1'b1);
      tick();
      check("t4_bubble", e_valid, 1'b0);
      m_rn = 5'd7; m_wreg = 1'b1;
      #1 check("t4_stall_once", stall, 1'b0);
      tick();
      check("t4_valid", e_valid, 1'b1);
      check("t4_adepend", adepend, 2'b11);
      $display("T4 load-use   : e_valid=%b adepend=%b", e_valid, adepend);
      m_wreg = 1'b0;

      // T5: jal writes r31, r0 never forwarded, imm/sa overrides
      set_dec(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
      set_dec(1'b1, 5'd31, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("t5_jal", adepend, 2'b10);
      set_dec(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("t5_r0", {adepend, bdepend}, 4'b0000);
      set_dec(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd1, 5'd12, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      check("t5_imm", bdepend, 2'b01);
      set_dec(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd13, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("t5_shift", adepend, 2'b01);
      $display("T5 jal/r0/imm : done");

      // T6: flush and load-use in the same cycle
      set_dec(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_dec(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 check("t6_stall", stall, 1'b0);
`ifdef PIPE_IDEXE_PERF_EN
      snap_sc = stall_cnt; snap_bc = bubble_cnt;
`endif
      tick();
      check("t6_bubble", e_valid, 1'b0);
`ifdef PIPE_IDEXE_PERF_EN
      check("t6_bubble_cnt", bubble_cnt, snap_bc + 32'd1);
      check("t6_stall_cnt", stall_cnt, snap_sc);
`endif
      $display("T6 flush+stall: e_valid=%b", e_valid);

      // Randomized traffic with a mid-run asynchronous reset (T1)
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) begin
            #1 resetn = 1'b0;
            #1;
            check("t1_e_valid", e_valid, 1'b0);
            check("t1_ctrl", {ejal, ewreg, em2reg, ewmem}, 4'b0000);
            check("t1_data", {ea, ern0}, 37'd0);
            check("t1_sel", {adepend, bdepend}, 4'b0000);
            check("t1_stall", stall, 1'b0);
            $display("T1 mid-reset  : e_valid=%b stall=%b", e_valid, stall);
            tick();
            resetn = 1'b1;
         end
         randomize_inputs();
         tick();
      end

      @(negedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
